bin14_to_bcd_seq: RTL

Sequential shift-add-3 (double-dabble) converter. It consumes the unsigned 14-bit sum produced by the 14-bit carry adder and produces four packed BCD digits for the seven-segment display driver downstream. It converts one operand per start/done transaction and holds the last result stable between conversions.

---
 rtl/bin14_to_bcd_seq.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/bin14_to_bcd_seq.sv
// Sequential double-dabble converter: 14-bit unsigned binary to 4 packed BCD digits, saturating at 9999.
// Latency: start accepted at edge k, done pulses in the cycle after edge k+14; one conversion per 15 cycles.
// Backpressure: start is ignored while busy; a new operand can be accepted in the done cycle.
module bin14_to_bcd_seq #(
  parameter int IN_WIDTH = 14,
  parameter int DIGITS   = 4,
  parameter int MAX_VAL  = 9999
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [IN_WIDTH-1:0]   bin_in,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  overflow
);

  // One spare digit so values above MAX_VAL convert without wrapping.
  localparam int                   ACC_W    = 4 * (DIGITS + 1);
  localparam int                   NIBS     = DIGITS + 1;
  localparam logic [3:0]           LAST_CNT = 4'(IN_WIDTH - 1);
  localparam logic [IN_WIDTH-1:0]  MAX_IN   = IN_WIDTH'(MAX_VAL);
  localparam logic [4*DIGITS-1:0]  SAT_BCD  = {DIGITS{4'h9}};

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_CONVERT = 2'd1,
    S_DONE    = 2'd2
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [ACC_W-1:0]      r_acc;
  logic [ACC_W-1:0]      w_acc_nxt;
  logic [IN_WIDTH-1:0]   r_shreg;
  logic [3:0]            r_count;
  logic                  r_ovf_pend;
  logic                  w_accept;
  logic                  w_commit;
  logic [3:0]            w_nib;
  logic                  w_carry;

  // State register; reset always returns to IDLE, aborting any conversion.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state decode plus busy/done strobes and the accept/commit controls.
  always_comb begin
    w_state_nxt = r_state;
    busy        = 1'b0;
    done        = 1'b0;
    w_accept    = 1'b0;
    w_commit    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_accept    = 1'b1;
          w_state_nxt = S_CONVERT;
        end
      end
      S_CONVERT: begin
        busy = 1'b1;
        if (r_count == LAST_CNT) begin
          w_commit    = 1'b1;
          w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        done = 1'b1;
        if (start) begin
          w_accept    = 1'b1;
          w_state_nxt = S_CONVERT;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // One double-dabble step: add 3 to every nibble >= 5, then shift left with
  // the binary MSB entering the units digit and each nibble's MSB carrying up.
  always_comb begin
    w_acc_nxt = '0;
    w_nib     = '0;
    w_carry   = r_shreg[IN_WIDTH-1];
    for (int i = 0; i < NIBS; i++) begin
      w_nib = r_acc[4*i +: 4];
      if (w_nib >= 4'd5) begin
        w_nib = w_nib + 4'd3;
      end
      w_acc_nxt[4*i +: 4] = {w_nib[2:0], w_carry};
      w_carry             = w_nib[3];
    end
  end

  // Scratch registers: loaded on accept, stepped once per CONVERT cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_acc      <= '0;
      r_shreg    <= '0;
      r_count    <= '0;
      r_ovf_pend <= 1'b0;
    end else if (w_accept) begin
      r_acc      <= '0;
      r_shreg    <= bin_in;
      r_count    <= '0;
      r_ovf_pend <= (bin_in > MAX_IN);
    end else if (r_state == S_CONVERT) begin
      r_acc      <= w_acc_nxt;
      r_shreg    <= {r_shreg[IN_WIDTH-2:0], 1'b0};
      r_count    <= r_count + 4'd1;
    end
  end

  // Result registers change only at the commit edge, so the display holds steady between conversions.
  always_ff @(posedge clk) begin
    if (reset) begin
      bcd      <= '0;
      overflow <= 1'b0;
    end else if (w_commit) begin
      if (r_ovf_pend) begin
        bcd      <= SAT_BCD;
        overflow <= 1'b1;
      end else begin
        bcd      <= w_acc_nxt[4*DIGITS-1:0];
        overflow <= 1'b0;
      end
    end
  end

endmodule
